// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_e   : fetch FSM states (IDLE, ISSUE, WAIT, HOLD)
//   inc_shift : log2 of the sequential PC increment; this is how many low PC bits
//               a redirect target has cleared so that it stays aligned.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic int unsigned inc_shift(input int unsigned inc);
    return $clog2(inc);
  endfunction

endpackage

// File: rtl/step_edge.sv
// Debug step-button edge detector.
// Keeps a two-flop history of the raw button level and emits a one-cycle pulse
// when the history shows a 0 -> 1 transition.
//   Clk        in  clock, rising edge
//   Rst        in  synchronous active-low reset; the history resets to 1 so that
//                  a button held down through reset does not produce a pulse
//   step       in  raw button level
//   step_pulse out one-cycle pulse per rising edge of step
module step_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic step,
  output logic step_pulse
);

  logic [1:0] hist_q, hist_d;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally); a missed path would infer a latch.
  always_comb begin
    hist_d = {hist_q[0], step};
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  // hist_q[0] is the newer sample, hist_q[1] the older one.
  assign step_pulse = hist_q[0] & ~hist_q[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues synchronous reads to instruction
// memory and hands {pc, instr} to decode over a valid/ready handshake.
// FSM: IDLE -> ISSUE (imem_en) -> WAIT (capture read data) -> HOLD (out_valid)
// -> ISSUE in free-run or IDLE in single-step. A redirect overrides any state.
//   Clk, Rst          clock / synchronous active-low reset
//   run_mode, step    free-run enable / raw single-step button level
//   redirect_valid/pc branch or jump target; low log2(PC_INC) bits are cleared
//   imem_en/addr      read strobe and address (address is the PC register)
//   imem_rdata        read data, valid the cycle after imem_en
//   out_valid/ready   handshake to decode; out_pc / out_instr are the payload
//   fetch_count       number of accepted instructions, wraps
// Optional build macro BREAKPOINT_EN adds bp_en, bp_addr and a sticky bp_hit
// that halts free-run before fetching from bp_addr; a step pulse resumes.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_INC   = 4,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               run_mode,
  input  logic               step,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
`ifdef BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  output logic               bp_hit,
`endif
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam int unsigned       INC_SHIFT  = inc_shift(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << INC_SHIFT) - ADDR_W'(1));

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic               imem_en_q, imem_en_d;
  logic               out_valid_q, out_valid_d;
  logic               step_pulse;
  logic               run_eff;
  logic               handshake;
  logic               run_issue;   // entering ISSUE because of free-run, not a step
`ifdef BREAKPOINT_EN
  logic               bp_hit_q, bp_hit_d;
`endif

  step_edge u_step_edge (
    .Clk       (Clk),
    .Rst       (Rst),
    .step      (step),
    .step_pulse(step_pulse)
  );

  always_comb begin
`ifdef BREAKPOINT_EN
    run_eff  = run_mode & ~bp_hit_q;
    bp_hit_d = bp_hit_q;
`else
    run_eff  = run_mode;
`endif
    handshake     = (state_q == HOLD) & out_ready;
    state_d       = state_q;
    pc_d          = pc_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    fetch_count_d = fetch_count_q + CNT_W'(handshake);
    run_issue     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A step pulse outside IDLE is dropped simply by not being looked at.
        if (step_pulse) begin
          state_d = ISSUE;
`ifdef BREAKPOINT_EN
          bp_hit_d = 1'b0;
`endif
        end else if (run_eff) begin
          state_d   = ISSUE;
          run_issue = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        out_pc_d    = pc_q;
        out_instr_d = imem_rdata;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          pc_d = pc_q + ADDR_W'(PC_INC);
          if (run_eff) begin
            state_d   = ISSUE;
            run_issue = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over the FSM; the handshake count above still stands, and
    // any read in flight is dropped by leaving the payload registers alone.
    if (redirect_valid) begin
      pc_d        = redirect_pc & ALIGN_MASK;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      state_d     = run_eff ? ISSUE : IDLE;
      run_issue   = run_eff;
`ifdef BREAKPOINT_EN
      bp_hit_d    = bp_hit_q;
`endif
    end

`ifdef BREAKPOINT_EN
    // Free-run halts before fetching from the breakpoint address.
    if (run_issue && bp_en && (pc_d == bp_addr)) begin
      state_d  = IDLE;
      bp_hit_d = 1'b1;
    end
`endif

    imem_en_d   = (state_d == ISSUE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      out_pc_q      <= '0;
      out_instr_q   <= '0;
      fetch_count_q <= '0;
      imem_en_q     <= 1'b0;
      out_valid_q   <= 1'b0;
`ifdef BREAKPOINT_EN
      bp_hit_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      fetch_count_q <= fetch_count_d;
      imem_en_q     <= imem_en_d;
      out_valid_q   <= out_valid_d;
`ifdef BREAKPOINT_EN
      bp_hit_q      <= bp_hit_d;
`endif
    end
  end

  assign imem_en     = imem_en_q;
  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_instr   = out_instr_q;
  assign fetch_count = fetch_count_q;
`ifdef BREAKPOINT_EN
  assign bp_hit      = bp_hit_q;
`endif

endmodule
